// File: rtl/acc_request_pkg.sv
// Shared widths and FSM state encoding for the accumulator request generator.
package acc_request_pkg;

  localparam int ACC_W = 32;
  localparam int CYC_W = 64;

  typedef enum logic [1:0] {
    INIT = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2,
    HALT = 2'd3
  } acc_state_e;

endpackage

// File: rtl/acc_request_gen_if.sv
// Request bus between the generator and the accumulator it drives.
interface acc_request_gen_if;
  import acc_request_pkg::*;

  logic [CYC_W-1:0] cycles;
  logic [ACC_W-1:0] accumulator;
  logic             valid;
  logic [ACC_W-1:0] value;

  modport master (
    input  cycles,
    input  accumulator,
    output valid,
    output value
  );

  modport slave (
    output cycles,
    output accumulator,
    input  valid,
    input  value
  );

endinterface

// File: rtl/acc_slot_timer.sv
// Slot strobe: high whenever the low PERIOD_LOG2 bits of the cycle count are zero.
module acc_slot_timer
  import acc_request_pkg::*;
#(
  parameter int PERIOD_LOG2 = 2
) (
  input  logic [CYC_W-1:0] cycles,
  output logic             slot
);

  // Masking the full count keeps every bit of the bus in use.
  localparam logic [CYC_W-1:0] PERIOD_MASK = (CYC_W'(1) << PERIOD_LOG2) - CYC_W'(1);

  assign slot = ((cycles & PERIOD_MASK) == '0);

endmodule

// File: rtl/acc_request_gen.sv
// Ramp request generator feeding an external accumulator and tracking a shadow sum.
// Optional build macro ACC_CHECK_EN adds the shadow-vs-accumulator check and HALT.
module acc_request_gen
  import acc_request_pkg::*;
#(
  parameter int               PERIOD_LOG2 = 2,
  parameter logic [ACC_W-1:0] STEP        = 32'd1,
  parameter logic [ACC_W-1:0] LIMIT       = 32'd1000
) (
  input logic         clock,
  input logic         reset,
  acc_request_gen_if.master bus
);

  // state | meaning
  // INIT  | capture accumulator as shadow baseline
  // RUN   | issue one request per free slot while under LIMIT
  // DONE  | next increment would exceed LIMIT; idle until reset
  // HALT  | accumulator disagreed with shadow; idle until reset
  localparam logic [1:0] S_INIT = INIT;
  localparam logic [1:0] S_RUN  = RUN;
  localparam logic [1:0] S_DONE = DONE;
  localparam logic [1:0] S_HALT = HALT;

  logic [1:0]         state;
  logic [ACC_W-1:0]   k;
  logic [ACC_W-1:0]   shadow;
  logic               check_pending;
  logic               valid_q;
  logic [ACC_W-1:0]   value_q;
  logic               slot;
  logic [2*ACC_W-1:0] incr_full;
  logic [ACC_W-1:0]   incr;
  logic [ACC_W:0]     next_sum;
  logic               limit_ok;

  acc_slot_timer #(
    .PERIOD_LOG2 (PERIOD_LOG2)
  ) u_slot_timer (
    .cycles (bus.cycles),
    .slot   (slot)
  );

  // Any non-zero upper half means the increment alone is beyond 32 bits.
  assign incr_full = {{ACC_W{1'b0}}, k} * {{ACC_W{1'b0}}, STEP};
  assign incr      = incr_full[ACC_W-1:0];
  assign next_sum  = {1'b0, shadow} + {1'b0, incr};
  assign limit_ok  = (incr_full[2*ACC_W-1:ACC_W] == '0) && (next_sum <= {1'b0, LIMIT});

  assign bus.valid = valid_q;
  assign bus.value = value_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state         <= S_INIT;
      k             <= {{(ACC_W-1){1'b0}}, 1'b1};
      shadow        <= '0;
      check_pending <= 1'b0;
      valid_q       <= 1'b0;
      value_q       <= '0;
    end else begin
      case (state)
        S_INIT: begin
          shadow <= bus.accumulator;
          state  <= S_RUN;
        end
        S_RUN: begin
          if (valid_q) begin
            shadow        <= shadow + value_q;
            valid_q       <= 1'b0;
            check_pending <= 1'b1;
            if (k != '1) begin
              k <= k + 1'b1;
            end
          end else if (check_pending) begin
            check_pending <= 1'b0;
`ifdef ACC_CHECK_EN
            if (bus.accumulator != shadow) begin
              state <= S_HALT;
            end
`endif
          end else if (slot) begin
            if (limit_ok) begin
              valid_q <= 1'b1;
              value_q <= incr;
            end else begin
              state <= S_DONE;
            end
          end
        end
        S_DONE, S_HALT: begin
          valid_q <= 1'b0;
        end
        default: begin
          state <= S_INIT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_acc_request_gen.sv
// Self-checking bench: four generator instances against an arithmetic ramp model.
module tb_acc_request_gen;
  import acc_request_pkg::*;

  localparam int NDUT = 4;
`ifdef ACC_CHECK_EN
  localparam bit CHECK_EN = 1'b1;
`else
  localparam bit CHECK_EN = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset;
  logic [63:0] cyc;
  logic [31:0] acc [NDUT];

  always #5 clock = ~clock;

  acc_request_gen_if if_a ();
  acc_request_gen_if if_z ();
  acc_request_gen_if if_b ();
  acc_request_gen_if if_r ();

  assign if_a.cycles = cyc;
  assign if_z.cycles = cyc;
  assign if_b.cycles = cyc;
  assign if_r.cycles = cyc;
  assign if_a.accumulator = acc[0];
  assign if_z.accumulator = acc[1];
  assign if_b.accumulator = acc[2];
  assign if_r.accumulator = acc[3];

  acc_request_gen #(.PERIOD_LOG2(2), .STEP(32'd1), .LIMIT(32'd10))
    u_a (.clock(clock), .reset(reset), .bus(if_a.master));
  acc_request_gen #(.PERIOD_LOG2(2), .STEP(32'd1), .LIMIT(32'd0))
    u_z (.clock(clock), .reset(reset), .bus(if_z.master));
  acc_request_gen #(.PERIOD_LOG2(2), .STEP(32'd2), .LIMIT(32'd11))
    u_b (.clock(clock), .reset(reset), .bus(if_b.master));
  acc_request_gen #(.PERIOD_LOG2(3), .STEP(32'd3), .LIMIT(32'd200))
    u_r (.clock(clock), .reset(reset), .bus(if_r.master));

  logic        ov   [NDUT];
  logic [31:0] oval [NDUT];
  logic [1:0]  ost  [NDUT];

  always_comb begin
    ov[0] = if_a.valid;  oval[0] = if_a.value;  ost[0] = u_a.state;
    ov[1] = if_z.valid;  oval[1] = if_z.value;  ost[1] = u_z.state;
    ov[2] = if_b.valid;  oval[2] = if_b.value;  ost[2] = u_b.state;
    ov[3] = if_r.valid;  oval[3] = if_r.value;  ost[3] = u_r.state;
  end

  // Reference model: request k lands on the k-th slot after baseline capture and
  // is issued while baseline + STEP*k*(k+1)/2 stays within LIMIT.
  longint unsigned m_step  [NDUT] = '{1, 1, 2, 3};
  longint unsigned m_limit [NDUT] = '{10, 0, 11, 200};
  int              m_plog  [NDUT] = '{2, 2, 2, 3};
  longint unsigned m_base  [NDUT];
  longint unsigned m_s1    [NDUT];
  bit              m_done  [NDUT];
  bit              m_halted[NDUT];
  bit              halt_arm[NDUT];
  bit              drop_pend[NDUT];
  logic [31:0]     m_last  [NDUT];
  int              drop_a_k;

  int checks;
  int errors;

  task automatic chk(input string tag, input int d, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s[%0d] observed=%0h expected=%0h", tag, d, obs, exp);
    end
  endtask

  function automatic logic [1:0] exp_state(input int d);
    acc_state_e s;
    if (CHECK_EN && m_halted[d]) s = HALT;
    else if (m_done[d])          s = DONE;
    else                         s = RUN;
    return s;
  endfunction

  task automatic release_reset();
    for (int d = 0; d < NDUT; d++) begin
      m_base[d]    = 64'(acc[d]);
      m_s1[d]      = ((cyc >> m_plog[d]) + 64'd1) << m_plog[d];
      m_done[d]    = 1'b0;
      m_halted[d]  = 1'b0;
      halt_arm[d]  = 1'b0;
      drop_pend[d] = 1'b0;
      m_last[d]    = '0;
    end
    reset = 1'b0;
  endtask

  task automatic step();
    logic            pv   [NDUT];
    logic [31:0]     pval [NDUT];
    longint unsigned c, p, k;
    logic            issue;
    logic [31:0]     ev;
    for (int d = 0; d < NDUT; d++) begin
      pv[d]   = ov[d];
      pval[d] = oval[d];
    end
    c = cyc;
    @(posedge clock);
    #1;
    for (int d = 0; d < NDUT; d++) begin
      if (halt_arm[d]) begin
        m_halted[d] = 1'b1;
        halt_arm[d] = 1'b0;
      end
      if (pv[d]) begin
        if (drop_pend[d]) halt_arm[d] = 1'b1;
        else              acc[d] = acc[d] + pval[d];
        drop_pend[d] = 1'b0;
      end
      if (reset) begin
        chk("valid_in_reset", d, 64'(ov[d]), 64'd0);
        chk("value_in_reset", d, 64'(oval[d]), 64'd0);
      end else begin
        p = 64'd1 << m_plog[d];
        k = 0;
        issue = 1'b0;
        ev = m_last[d];
        if (c >= m_s1[d] && ((c - m_s1[d]) % p) == 0 && !m_done[d] && !(CHECK_EN && m_halted[d])) begin
          k = (c - m_s1[d]) / p + 64'd1;
          if (m_base[d] + m_step[d] * k * (k + 64'd1) / 64'd2 <= m_limit[d]) begin
            issue = 1'b1;
            ev = 32'(k * m_step[d]);
          end else begin
            m_done[d] = 1'b1;
          end
        end
        chk("valid", d, 64'(ov[d]), 64'(issue));
        chk("value", d, 64'(oval[d]), 64'(ev));
        m_last[d] = ev;
        if (issue)
          drop_pend[d] = (d == 0 && k == 64'(drop_a_k)) || (d == 3 && $urandom_range(0, 5) == 0);
      end
    end
    cyc = cyc + 64'd1;
  endtask

  task automatic check_states();
    for (int d = 0; d < NDUT; d++) chk("state", d, 64'(ost[d]), 64'(exp_state(d)));
  endtask

  initial begin
    bit seen;
    checks   = 0;
    errors   = 0;
    drop_a_k = 0;
    reset    = 1'b1;
    cyc      = {32'h0, $urandom};
    acc[0]   = 32'd0;
    acc[1]   = 32'd0;
    acc[2]   = 32'd5;
    acc[3]   = $urandom_range(0, 40);
    for (int d = 0; d < NDUT; d++) m_last[d] = '0;

    // Reset state
    repeat (2 + $urandom_range(0, 3)) step();
    for (int d = 0; d < NDUT; d++) chk("state_reset", d, 64'(ost[d]), 64'(INIT));
    chk("k_reset", 0, 64'(u_a.k), 64'd1);
    chk("shadow_reset", 0, 64'(u_a.shadow), 64'd0);

    // Phase 1: plain ramps from their baselines
    release_reset();
    repeat (150) step();
    check_states();
    chk("acc_final_ramp", 0, 64'(acc[0]), 64'd10);
    chk("acc_final_base5", 2, 64'(acc[2]), 64'd11);

    // Phase 2: reset in the middle of the ramp
    reset = 1'b1;
    #1;
    acc[0] = 32'd0;
    acc[1] = $urandom_range(0, 20);
    acc[3] = $urandom_range(0, 40);
    repeat (3) step();
    release_reset();
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      step();
      if (ov[0] && oval[0] == 32'd2) seen = 1'b1;
    end
    chk("a_req2_seen", 0, 64'(seen), 64'd1);
    reset = 1'b1;
    #1;
    for (int d = 0; d < NDUT; d++) begin
      chk("valid_async_clear", d, 64'(ov[d]), 64'd0);
      chk("value_async_clear", d, 64'(oval[d]), 64'd0);
      chk("state_async_clear", d, 64'(ost[d]), 64'(INIT));
    end
    acc[0] = 32'd3;
    acc[2] = 32'd5;
    repeat (3) step();
    release_reset();
    step();
    chk("shadow_rebase", 0, 64'(u_a.shadow), 64'd3);
    repeat (150) step();
    check_states();
    chk("acc_final_rebase", 0, 64'(acc[0]), 64'd9);

    // Phase 3: first request on u_a is ignored by the accumulator
    reset = 1'b1;
    #1;
    acc[0] = 32'd0;
    acc[3] = $urandom_range(0, 40);
    drop_a_k = 1;
    repeat (2 + $urandom_range(0, 4)) step();
    release_reset();
    repeat (150) step();
    check_states();
    chk("acc_final_drop", 0, 64'(acc[0]), CHECK_EN ? 64'd0 : 64'd9);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
